// File: rtl/fb_reader.sv
// rtl/fb_reader.sv - frame buffer reader: linear SDRAM reads into a first-word-fall-through pixel FIFO
// One read outstanding at a time; a FIFO slot is reserved before each request is issued.
module fb_reader #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] frame_base,
  output logic [23:0] rd_addr,
  output logic        rd_enable,
  input  logic [15:0] rd_data,
  input  logic        rd_ready,
  input  logic        busy,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic        active
);
  localparam int TOTAL = H_RES * V_RES;
  localparam int CW    = $clog2(TOTAL) + 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW    = AW + 1;
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
  localparam logic [CW-1:0] X_LAST  = CW'(H_RES - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(V_RES - 1);
  localparam logic [NW-1:0] DEPTH_C = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t        state;
  logic [23:0]   addr;
  logic [CW-1:0] rd_count, out_x, out_y, x_next, y_next;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [NW-1:0] fifo_count, count_next;
  logic [15:0]   head_next;
  logic          push, pop, last_pix;

  always_comb begin
    push        = (state == WAIT) && rd_ready;
    pop         = pix_valid && pix_ready;
    last_pix    = (out_x == X_LAST) && (out_y == Y_LAST);
    count_next  = fifo_count + NW'(push) - NW'(pop);
    rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;
    // A push into a FIFO that is empty after this cycle's pop bypasses the array.
    head_next   = (push && count_next == NW'(1)) ? rd_data : mem[rd_ptr_next];
    x_next      = out_x;
    y_next      = out_y;
    if (state == IDLE && start) begin
      x_next = '0;
      y_next = '0;
    end else if (pop) begin
      if (out_x == X_LAST) begin
        x_next = '0;
        y_next = (out_y == Y_LAST) ? '0 : out_y + CW'(1);
      end else begin
        x_next = out_x + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_x      <= '0;
      out_y      <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_next;
      fifo_count <= count_next;
      out_x      <= x_next;
      out_y      <= y_next;
      pix_valid  <= (count_next != '0);
      if (count_next != '0) pix_data <= head_next;
      pix_sof    <= (count_next != '0) && (x_next == '0) && (y_next == '0);
      pix_eol    <= (count_next != '0) && (x_next == X_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      rd_count   <= '0;
      rd_addr    <= '0;
      rd_enable  <= 1'b0;
      frame_done <= 1'b0;
      active     <= 1'b0;
    end else begin
      rd_enable  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addr     <= frame_base;
          rd_count <= '0;
          active   <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: if (!busy && fifo_count < DEPTH_C) begin
          rd_enable <= 1'b1;
          rd_addr   <= addr;
          state     <= WAIT;
        end
        WAIT: if (rd_ready) begin
          addr     <= addr + 24'd1;
          rd_count <= rd_count + CW'(1);
          state    <= (rd_count + CW'(1) == TOTAL_C) ? DRAIN : ISSUE;
        end
        DRAIN: if (pop && last_pix) begin
          frame_done <= 1'b1;
          active     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_reader.sv
// tb/tb_fb_reader.sv - randomized self-checking bench for fb_reader
// Expected addresses and pixels follow frame_base + index; the controller and consumer are modelled here.
module tb_fb_reader;
  localparam int H = 4, V = 2, D = 4, TOTAL = H * V;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        rd_ready = 1'b0, busy = 1'b0, pix_ready = 1'b0;
  logic [23:0] frame_base = '0;
  logic [15:0] rd_data = '0;
  logic [23:0] rd_addr;
  logic [15:0] pix_data;
  logic        rd_enable, pix_valid, pix_sof, pix_eol, frame_done, active;

  fb_reader #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_base(frame_base),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done), .active(active)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  // owned by the main process
  logic [23:0] fr_base = '0;
  int fr_req0 = 0, fr_pix0 = 0, fr_done0 = 0;
  int prdy_mode = 0;
  bit lat_rand = 0, spur_en = 0, rand_busy = 0, busy_force = 0, busy_test = 0, inject_start = 0;
  // owned by the model process
  int req_cnt = 0, pix_cnt = 0, done_cnt = 0, cyc = 0, cnt = 0, fall_cyc = -1, first_req = -1;
  bit pend = 0, last_prev = 0, nb = 0;
  logic [23:0] pend_addr = '0, ea = '0;
  int pi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_enable"}, 32'(rd_enable), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_sof"}, 32'(pix_sof), 32'd0);
    check({tag, "_pix_eol"}, 32'(pix_eol), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
  endtask

  // Controller, consumer and scoreboard; all inputs change and all outputs are sampled on negedge.
  always @(negedge clk) begin
    cyc++;
    if (busy) check("no_req_while_busy", 32'(rd_enable), 32'd0);
    rd_ready = 1'b0;
    if (rd_enable) begin
      check("one_outstanding", 32'(pend), 32'd0);
      ea = fr_base + 24'(req_cnt - fr_req0);
      check("rd_addr", 32'(rd_addr), 32'(ea));
      req_cnt++;
      pend = 1'b1;
      pend_addr = rd_addr;
      cnt = lat_rand ? int'($urandom_range(1, 3)) : 2;
      if (busy_test && first_req < 0) first_req = cyc;
    end else if (pend) begin
      if (cnt <= 1) begin
        rd_ready = 1'b1;
        rd_data = pend_addr[15:0];
        pend = 1'b0;
      end else begin
        cnt--;
      end
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      rd_ready = 1'b1;
      rd_data = 16'hdead;
    end
    nb = busy_force || (rand_busy && $urandom_range(0, 3) == 0);
    if (busy_test && busy && !nb && fall_cyc < 0) fall_cyc = cyc;
    busy = nb;

    if (frame_done) begin
      check("done_timing", 32'(last_prev), 32'd1);
      done_cnt++;
    end
    last_prev = 1'b0;
    pix_ready = (prdy_mode == 0) ? 1'b1 : (prdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (pix_valid && pix_ready) begin
      pi = pix_cnt - fr_pix0;
      ea = fr_base + 24'(pi);
      check("pixel", {14'd0, pix_sof, pix_eol, pix_data},
            {14'd0, (pi == 0), (pi % H == H - 1), ea[15:0]});
      last_prev = (pi == TOTAL - 1);
      pix_cnt++;
    end
  end

  task automatic frame_begin(input logic [23:0] b);
    @(negedge clk);
    fr_base = b;
    fr_req0 = req_cnt;
    fr_pix0 = pix_cnt;
    fr_done0 = done_cnt;
    frame_base = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("active_after_start", 32'(active), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == fr_done0 && n < 3000) begin
      @(negedge clk);
      n++;
      if (start) start = 1'b0;
      else if (inject_start && active && $urandom_range(0, 7) == 0) start = 1'b1;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - fr_done0), 32'd1);
    check({tag, "_pixels"}, 32'(pix_cnt - fr_pix0), 32'(TOTAL));
    check({tag, "_requests"}, 32'(req_cnt - fr_req0), 32'(TOTAL));
    check({tag, "_active_end"}, 32'(active), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    frame_begin(24'h000100);
    wait_done("basic");

    prdy_mode = 2;
    frame_begin(24'h002000);
    repeat (40) @(negedge clk);
    check("bp_requests", 32'(req_cnt - fr_req0), 32'(D));
    check("bp_no_pixels", 32'(pix_cnt - fr_pix0), 32'd0);
    check("bp_valid", 32'(pix_valid), 32'd1);
    prdy_mode = 0;
    wait_done("backpressure");

    busy_force = 1;
    busy_test = 1;
    @(negedge clk);
    frame_begin(24'h000300);
    repeat (10) @(negedge clk);
    check("busy_no_req", 32'(req_cnt - fr_req0), 32'd0);
    busy_force = 0;
    wait_done("busy");
    check("busy_first_req", 32'(first_req - fall_cyc), 32'd1);
    busy_test = 0;

    frame_begin(24'hfffffe);
    wait_done("wrap");

    lat_rand = 1; prdy_mode = 1; spur_en = 1; rand_busy = 1; inject_start = 1;
    for (int f = 0; f < 8; f++) begin
      frame_begin(24'($urandom));
      wait_done("random");
    end
    lat_rand = 0; prdy_mode = 0; spur_en = 0; rand_busy = 0; inject_start = 0;

    frame_begin(24'h004000);
    n = 0;
    while (pix_cnt - fr_pix0 < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_pixels", 32'(pix_cnt - fr_pix0 >= 3), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("late_rd_ready_ignored", 32'(pix_valid), 32'd0);
    frame_begin(24'h004000);
    wait_done("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected end of test");
    $fatal(1, "simulation timeout");
  end
endmodule
